// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first: one full-subtractor cell reused across all bit positions,
// with a registered borrow between bits and a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only while idle (busy=0, done=0); a/b are captured on that edge.
  // done is a one-cycle pulse; diff/bout/ovf are stable from the done cycle until the next done.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_ai       = r_a[0];
  assign w_bi       = r_b[0];
  assign w_d        = w_ai ^ w_bi ^ r_br;
  assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE:  begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          // Hold the counter on the last bit so it never wraps.
          if (!w_last) r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br_next;
            r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed vectors, expected results queued by the
// driver and popped by a monitor on every done pulse.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int RW = W + 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic [1:0]   dbg_state;

  logic [RW-1:0] exp_q[$];
  int            done_cyc[$];
  int            n_total = 0;
  int            n_pass  = 0;
  int            n_done  = 0;
  int            cyc     = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result{diff,bout,ovf}", 32'({diff, bout, ovf}), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int nb;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    exp_q.push_back({ed, eb, eo});
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(nb), 32'(W));
    check("done_after_busy", 32'(done), 32'd1);
    @(negedge clk);
    check("idle_after_done", 32'({busy, done}), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int base;
    int k;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    wait_cycles(3);
    check("reset_outputs", 32'({busy, done, diff, bout, ovf}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    check("diff_holds", 32'(diff), 32'h80);

    // second start during busy cycle 4 must be ignored
    base = n_done;
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h01;
    exp_q.push_back({8'h0F, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    wait_cycles(3);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(25);
    check("ignored_start_done_count", 32'(n_done - base), 32'd1);

    // back-to-back with start held high
    base = n_done;
    k = done_cyc.size();
    for (int i = 0; i < 3; i++) exp_q.push_back({8'h37, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h23;
    for (int i = 0; i < 60 && n_done < base + 3; i++) @(negedge clk);
    start = 1'b0;
    check("b2b_done_count", 32'(n_done - base), 32'd3);
    if (done_cyc.size() >= k + 3) begin
      check("b2b_gap1", 32'(done_cyc[k+1] - done_cyc[k]), 32'(W + 2));
      check("b2b_gap2", 32'(done_cyc[k+2] - done_cyc[k+1]), 32'(W + 2));
    end
    wait_cycles(15);
    check("b2b_no_extra", 32'(n_done - base), 32'd3);

    // reset abort in busy cycle 3
    base = n_done;
    @(negedge clk);
    start = 1'b1; a = 8'h44; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(2);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", 32'({busy, done, diff, bout, ovf}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    wait_cycles(15);
    check("abort_no_done", 32'(n_done - base), 32'd0);

    run_op(8'h07, 8'h09, 8'hFE, 1'b1, 1'b0);
    wait_cycles(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
